// File: rtl/rv_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU FSM states and
// the legality/alignment check used by the load/store unit.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // True when funct3 is defined for the access direction and the address is
  // naturally aligned to the access size encoded in funct3[1:0].
  function automatic logic req_ok(input logic we, input logic [2:0] funct3,
                                  input logic [1:0] addr_lo);
    logic defined;
    logic aligned;
    if (we)
      defined = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else
      defined = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                (funct3 == F3_BU) || (funct3 == F3_HU);
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = !addr_lo[0];
      default: aligned = (addr_lo == 2'b00);
    endcase
    return defined && aligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and store-data replication for the
// bus, lane selection plus sign/zero extension for returned load data.
module lsu_align
  import rv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata_ext
);

  logic [7:0]         b_sel;
  logic [15:0]        h_sel;
  logic signed [7:0]  b_s;
  logic signed [15:0] h_s;

  always_comb begin
    be        = '0;
    wdata_rep = '0;
    case (funct3[1:0])
      2'b00: begin
        be        = BE_W'(1) << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = BE_W'(3) << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be        = '1;
        wdata_rep = wdata;
      end
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'b00:   b_sel = rdata[7:0];
      2'b01:   b_sel = rdata[15:8];
      2'b10:   b_sel = rdata[23:16];
      default: b_sel = rdata[31:24];
    endcase
    h_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    b_s   = signed'(b_sel);
    h_s   = signed'(h_sel);
    case (funct3)
      F3_B:    rdata_ext = XLEN'(b_s);
      F3_H:    rdata_ext = XLEN'(h_s);
      F3_BU:   rdata_ext = XLEN'(b_sel);
      F3_HU:   rdata_ext = XLEN'(h_sel);
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one RV32I memory op from the core, runs a
// single bus transaction with grant/response handshake and optional timeout.
module lsu_ctrl
  import rv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            req_err,
  output logic            bus_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_e      state;
  lsu_state_e      state_nxt;
  logic            lat_we;
  logic [2:0]      lat_f3;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic [XLEN-1:0] rdata_q;
  logic [CNT_W-1:0] cnt;

  logic            legal;
  logic            accept;
  logic            reject;
  logic            to_hit;
  logic            abort;
  logic            capture;
  logic [BE_W-1:0] al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;

  // req_valid-driven outputs are gated by rst_n so nothing pulses while in reset
  assign legal   = req_ok(req_we, req_funct3, req_addr[1:0]);
  assign accept  = rst_n && (state == ST_IDLE) && req_valid && legal;
  assign reject  = rst_n && (state == ST_IDLE) && req_valid && !legal;
  assign to_hit  = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
  assign abort   = to_hit && (((state == ST_REQ) && !mem_gnt) ||
                              ((state == ST_WAIT) && !mem_rvalid));
  assign capture = ((state == ST_REQ) && mem_gnt && !lat_we && mem_rvalid) ||
                   ((state == ST_WAIT) && mem_rvalid);

  lsu_align u_align (
    .funct3    (lat_f3),
    .addr_lo   (lat_addr[1:0]),
    .wdata     (lat_wdata),
    .rdata     (rdata_q),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_REQ;
      ST_REQ: begin
        if (mem_gnt)
          state_nxt = (lat_we || mem_rvalid) ? ST_DONE : ST_WAIT;
        else if (abort)
          state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        if (mem_rvalid)  state_nxt = ST_DONE;
        else if (abort)  state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latches, load-data capture and bus-wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_f3    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_f3    <= req_funct3;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= '0;
      end else if ((state == ST_REQ) || (state == ST_WAIT)) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (capture) rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    stall     = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    req_err   = 1'b0;
    bus_err   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (state)
      ST_IDLE: begin
        stall   = accept;
        req_err = reject;
      end
      ST_REQ: begin
        stall     = !abort;
        bus_err   = abort;
        mem_req   = 1'b1;
        mem_we    = lat_we;
        mem_addr  = {lat_addr[XLEN-1:2], 2'b00};
        mem_wdata = lat_we ? al_wdata : '0;
        mem_be    = al_be;
      end
      ST_WAIT: begin
        stall   = !abort;
        bus_err = abort;
      end
      default: begin
        rsp_valid = 1'b1;
        rsp_rdata = lat_we ? '0 : al_rdata;
      end
    endcase
  end

endmodule
